// File: rtl/varredor_rom.sv
// Sequential ROM scanner: walks addresses from 0 until the terminator, accumulating
// sum, count, maximum and minimum of the consumed bytes.
module varredor_rom #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8,
    parameter logic [DATA_W-1:0] TERMINADOR = 8'hFF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Inicio,
    input  logic [DATA_W-1:0]        Dados,
    output logic [ADDR_W-1:0]        Endereco,
    output logic                     Ocupado,
    output logic                     Pronto,
    output logic                     Estouro,
    output logic [DATA_W+ADDR_W-1:0] Soma,
    output logic [ADDR_W:0]          Contagem,
    output logic [DATA_W-1:0]        Maximo,
    output logic [DATA_W-1:0]        Minimo
);

    localparam int unsigned SOMA_W = DATA_W + ADDR_W;
    localparam int unsigned CONT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ULTIMO = '1;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENDERECA = 2'd1,
        LEITURA  = 2'd2,
        FIM      = 2'd3
    } estado_t;

    estado_t estado;

    // Two cycles per word: present the address, then consume the returned byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado   <= OCIOSO;
            Endereco <= '0;
            Ocupado  <= 1'b0;
            Pronto   <= 1'b0;
            Estouro  <= 1'b0;
            Soma     <= '0;
            Contagem <= '0;
            Maximo   <= '0;
            Minimo   <= '0;
        end else begin
            case (estado)
                OCIOSO, FIM: begin
                    if (Inicio) begin
                        estado   <= ENDERECA;
                        Endereco <= '0;
                        Ocupado  <= 1'b1;
                        Pronto   <= 1'b0;
                        Estouro  <= 1'b0;
                        Soma     <= '0;
                        Contagem <= '0;
                        Maximo   <= '0;
                        Minimo   <= '0;
                    end
                end
                ENDERECA: begin
                    estado <= LEITURA;
                end
                LEITURA: begin
                    if (Dados == TERMINADOR) begin
                        estado  <= FIM;
                        Ocupado <= 1'b0;
                        Pronto  <= 1'b1;
                    end else begin
                        Soma     <= Soma + SOMA_W'(Dados);
                        Contagem <= Contagem + CONT_W'(1);
                        if (Dados > Maximo)
                            Maximo <= Dados;
                        if ((Contagem == '0) || (Dados < Minimo))
                            Minimo <= Dados;
                        // Last ROM word consumed without a terminator: stop, address does not wrap.
                        if (Endereco == ULTIMO) begin
                            estado  <= FIM;
                            Ocupado <= 1'b0;
                            Pronto  <= 1'b1;
                            Estouro <= 1'b1;
                        end else begin
                            Endereco <= Endereco + ADDR_W'(1);
                            estado   <= ENDERECA;
                        end
                    end
                end
                default: begin
                    estado  <= OCIOSO;
                    Ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
